// File: rtl/seg7_selector_if.sv
// Bus between the display data source and the seven-segment scan driver.
// The source owns the displayed value; the driver owns the pin-level outputs.
interface seg7_selector_if;
  logic [15:0] reg_16_i;
  logic [6:0]  seg_display_o;
  logic [3:0]  SS_o;

  modport master (
    output reg_16_i,
    input  seg_display_o,
    input  SS_o
  );

  modport slave (
    input  reg_16_i,
    output seg_display_o,
    output SS_o
  );
endinterface

// File: rtl/seg7_selector.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit is lit for DIGIT_TICKS cycles; segment and select lines are registered.
module seg7_selector #(
  parameter int DIGIT_TICKS = 12500,
  parameter int CNT_W       = 14
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  seg7_selector_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_LAST_TICK = CNT_W'(DIGIT_TICKS - 1);

  // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] r_tick_cnt;
  logic [1:0]       r_digit_idx;
  logic [3:0]       r_ss;
  logic [6:0]       r_seg;

  logic [3:0]       w_nib;
  logic             w_wrap;

  // Select the nibble belonging to the digit currently in its slot.
  always_comb begin
    w_nib = 4'h0;
    case (r_digit_idx)
      2'd0:    w_nib = bus.reg_16_i[3:0];
      2'd1:    w_nib = bus.reg_16_i[7:4];
      2'd2:    w_nib = bus.reg_16_i[11:8];
      2'd3:    w_nib = bus.reg_16_i[15:12];
      default: w_nib = 4'h0;
    endcase
  end

  assign w_wrap = (r_tick_cnt == LP_LAST_TICK);

  // Slot timer, digit rotation and registered pin drive.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= 2'd0;
      r_ss        <= 4'b1111;
      r_seg       <= 7'h7F;
    end else begin
      if (w_wrap) begin
        r_tick_cnt  <= '0;
        r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
        r_tick_cnt  <= r_tick_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        r_digit_idx <= r_digit_idx;
      end
      // Outputs trail the index by one cycle, so every slot still spans DIGIT_TICKS.
      r_ss  <= ~(4'b0001 << r_digit_idx);
      r_seg <= hex7(w_nib);
    end
  end

  assign bus.SS_o          = r_ss;
  assign bus.seg_display_o = r_seg;

endmodule

// File: tb/tb_seg7_selector.sv
// Scoreboard bench for seg7_selector with a shortened digit slot.
// Stimulus pushes expected pin states; a negedge monitor pops and compares.
module tb_seg7_selector;

  localparam int DT = 8;

  logic clk;
  logic rst_n;

  seg7_selector_if u_if ();

  seg7_selector #(
    .DIGIT_TICKS(DT),
    .CNT_W      (3)
  ) u_dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (u_if)
  );

  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [10:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_cnt = 0;
  logic [1:0]  m_idx = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected pin state per negedge while entries are pending.
  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (u_if.SS_o !== e[10:7] || u_if.seg_display_o !== e[6:0]) begin
        n_err++;
        $display("FAIL scan t=%0t: SS_o=%b seg=%h, expected SS_o=%b seg=%h",
                 $time, u_if.SS_o, u_if.seg_display_o, e[10:7], e[6:0]);
      end
    end
  end

  task automatic cyc(input logic [15:0] val);
    logic [15:0] sh;
    @(negedge clk);
    #1;
    u_if.reg_16_i = val;
    rst_n         = 1'b1;
    sh            = val >> (4 * int'(m_idx));
    exp_q.push_back({~(4'b0001 << m_idx), seg_tab[sh[3:0]]});
    if (m_cnt == DT - 1) begin
      m_cnt = 0;
      m_idx = m_idx + 2'd1;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic rst_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      m_cnt = 0;
      m_idx = 2'd0;
      exp_q.push_back({4'b1111, 7'h7F});
      if (i == 0) begin
        #1;
        n_vec++;
        if (u_if.SS_o !== 4'b1111 || u_if.seg_display_o !== 7'h7F) begin
          n_err++;
          $display("FAIL async_reset t=%0t: SS_o=%b seg=%h, expected SS_o=1111 seg=7f",
                   $time, u_if.SS_o, u_if.seg_display_o);
        end
      end
    end
  endtask

  initial begin
    int          scans;
    logic [3:0]  prev_ss;
    rst_n         = 1'b0;
    u_if.reg_16_i = 16'h0000;

    // T1 reset, T2 all zeros over a full scan
    rst_cyc(3);
    for (int i = 0; i < 4 * DT + 2; i++) cyc(16'h0000);

    // T3
    rst_cyc(1);
    for (int i = 0; i < 4 * DT; i++) cyc(16'h1234);

    // T4: full scan, then alternate values every cycle to expose latency
    for (int i = 0; i < 4 * DT; i++) cyc(16'hFEDC);
    for (int i = 0; i < 2 * DT; i++) cyc((i % 2 == 0) ? 16'h4321 : 16'hFEDC);

    // T5: reset while digit 2 is mid-slot, then a fresh scan
    while (!(m_idx == 2'd2 && m_cnt == DT / 2)) cyc(16'h9A5B);
    rst_cyc(5);
    for (int i = 0; i < 4 * DT + 3; i++) cyc(16'h8F07);

    // T6: exactly 10 scans between resets
    rst_cyc(2);
    scans   = 0;
    prev_ss = 4'b1111;
    for (int i = 0; i <= 40 * DT; i++) begin
      cyc(16'hA5C3);
      if (u_if.SS_o == 4'b1110 && prev_ss != 4'b1110) scans++;
      prev_ss = u_if.SS_o;
    end
    n_vec++;
    if (scans != 10) begin
      n_err++;
      $display("FAIL scan_count: got %0d scans, expected 10", scans);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
